// File: rtl/stream_rr_arbiter_if.sv
// Packet-stream bundle for the round-robin arbiter:
// NUM_REQ input streams in, one registered stream out.
interface stream_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            valid_s;
  logic [NUM_REQ-1:0]            ready_s;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_s;
  logic [NUM_REQ-1:0]            last_s;
  logic                          valid_m;
  logic                          ready_m;
  logic [DATA_WIDTH-1:0]         data_m;
  logic                          last_m;
  logic [ID_W-1:0]               id_m;

  modport master (
    input  valid_s, data_s, last_s, ready_m,
    output ready_s, valid_m, data_m, last_m, id_m
  );

  modport slave (
    output valid_s, data_s, last_s, ready_m,
    input  ready_s, valid_m, data_m, last_m, id_m
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin N:1 packet arbiter with a one-deep
// registered output relay; grants held per packet.
module stream_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  stream_rr_arbiter_if.master bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       gnt_q, gnt_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic [ID_W-1:0]       id_q, id_d;

  logic [ID_W-1:0]       sel;
  logic                  sel_vld;
  logic [ID_W:0]         sum;
  logic [ID_W-1:0]       idx;
  logic                  can_load;
  logic                  xfer;
  logic [NUM_REQ-1:0]    ready_s;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] =
      bus.data_s[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Pick the source: locked grant, else first valid from ptr.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    sum     = '0;
    idx     = '0;
    if (state_q == LOCKED) begin
      sel     = gnt_q;
      sel_vld = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(NUM_REQ))
          sum = sum - (ID_W+1)'(NUM_REQ);
        idx = sum[ID_W-1:0];
        if (!sel_vld && bus.valid_s[idx]) begin
          sel     = idx;
          sel_vld = 1'b1;
        end
      end
    end
  end

  // Accept into the relay only when it is empty or draining.
  always_comb begin
    can_load = !valid_q || bus.ready_m;
    ready_s  = '0;
    if (sel_vld && can_load)
      ready_s[sel] = 1'b1;
    xfer = sel_vld && can_load && bus.valid_s[sel];
  end

  // Relay load/drain and packet lock bookkeeping.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    id_d    = id_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = data_arr[sel];
      last_d  = bus.last_s[sel];
      id_d    = sel;
      if (bus.last_s[sel]) begin
        state_d = IDLE;
        if (sel == ID_W'(NUM_REQ - 1))
          ptr_d = '0;
        else
          ptr_d = sel + ID_W'(1);
      end else begin
        state_d = LOCKED;
        gnt_d   = sel;
      end
    end else if (bus.ready_m) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      id_q    <= id_d;
    end
  end

  assign bus.ready_s = ready_s;
  assign bus.valid_m = valid_q;
  assign bus.data_m  = data_q;
  assign bus.last_m  = last_q;
  assign bus.id_m    = id_q;
endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin N:1 arbiter that shares a single registered valid/ready output stage between NUM_REQ packet streams. Grants are held for a whole packet (until the beat with last_s set is accepted), so packets are never interleaved. The output stage is a one-deep relay register with full throughput and zero-bubble requester switching. It sits in front of any shared downstream consumer, such as a relay chain, FIFO or serializer.

## Interface
- NUM_REQ, 4, number of requesters (≥2; need not be a power of 2)
- DATA_WIDTH, 8, payload width per beat
- ID_W, $clog2(NUM_REQ), width of grant id (derived; not user-set)

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- valid_s  in  NUM_REQ  per-requester beat valid
- ready_s  out  NUM_REQ  per-requester beat accept; at most one bit high
- data_s  in  NUM_REQ*DATA_WIDTH  payloads; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- last_s  in  NUM_REQ  per-requester end-of-packet flag
- valid_m  out  1  output beat valid (registered)
- ready_m  in  1  downstream accept
- data_m  out  DATA_WIDTH  output payload (registered)
- last_m  out  1  output end-of-packet (registered)
- id_m  out  ID_W  index of requester that sourced the output beat (registered)

## Operation
- Definitions: transfer on input i = valid_s[i] && ready_s[i]; output transfer = valid_m && ready_m; can_load = !valid_m || ready_m.
- State: FSM {IDLE, LOCKED}, grant register gnt (ID_W), priority pointer ptr (ID_W).
- IDLE: sel = first i with valid_s[i]=1, searching ptr, ptr+1, …, wrapping modulo NUM_REQ. No valid_s set → no selection, all ready_s=0.
- LOCKED: sel = gnt, regardless of other valid_s. The granted requester may drop valid_s mid-packet; the lock holds.
- ready_s[i] = (i==sel) && can_load, plus in IDLE valid_s[i]=1. All other ready_s bits are 0.
- On an input transfer from sel: valid_m←1, data_m←data_s[sel], last_m←last_s[sel], id_m←sel.
  - last_s[sel]=1: state→IDLE, ptr←(sel+1) mod NUM_REQ.
  - last_s[sel]=0: state→LOCKED, gnt←sel.
- No input transfer and ready_m=1: valid_m←0. data_m, last_m and id_m hold their values.
- No input transfer and ready_m=0: all outputs hold.
- Single-beat packet (last_s=1 on first beat): never enters LOCKED.
- ptr changes only on an accepted last beat. Unserved requesters keep priority.

## Timing
- Reset (rst_n=0, immediate, async): valid_m=0, data_m=0, last_m=0, id_m=0, state=IDLE, gnt=0, ptr=0. ready_s then follows the combinational rules; valid_m=0 means the selected requester sees ready during reset.
  - Reset asserted mid-packet abandons the packet. Arbitration restarts at requester 0 with no lock.
- Latency: 1 cycle from input transfer to valid_m/data_m.
- Throughput: 1 beat/cycle sustained with ready_m=1, including across packet boundaries and requester switches.
- Simultaneous output transfer and input transfer in one cycle: valid_m stays 1 and the payload is replaced.
- Backpressure: valid_m=1 && ready_m=0 forces all ready_s=0. Output is held stable until accepted.
- ready_s depends combinationally on valid_s (IDLE), ready_m, valid_m and state. There is no combinational path from data_s or last_s to ready_s.

## Test plan
- Reset: drive rst_n=0 while LOCKED on requester 2 mid-packet → valid_m=0, id_m=0, ptr=0 with no clock edge. After release, requesters 0 and 2 both valid → requester 0 is granted first.
- Fairness: NUM_REQ=4, all four hold single-beat packets (last_s=1) continuously, ready_m=1 → id_m sequence 0,1,2,3,0,1 on consecutive cycles, valid_m constantly 1.
- Packet lock: requester 1 sends 3 beats 0xA1,0xA2,0xA3 (last on 0xA3); requester 0 valid throughout → data_m shows 0xA1,0xA2,0xA3 contiguously with id_m=1, ready_s[0]=0 until after 0xA3 is accepted, then requester 0 is granted the next cycle.
- Backpressure: hold ready_m=0 for 5 cycles with data_m=0x55 valid → ready_s all 0, data_m/last_m/id_m stable at 0x55. Raise ready_m → next beat loads the same cycle with no loss or duplication.
- Wrap/skip: ptr=3, only requesters 0 and 3 valid (single-beat) → grant 3, then 0, then 3. With only requester 2 valid, ptr=3 → grant 2.
- Lock with gap: requester 2 sends a non-last beat, then drops valid_s for 3 cycles while requester 1 is valid → ready_s[1]=0 throughout. Requester 2 resumes with its last beat, then requester 1 is granted.
